apb16_regbank: RTL and testbench
================================

# apb16_regbank

16-bit APB completer that sits directly downstream of `apb_downsizer` and consumes its narrow master-side transfers. It holds a halfword register array, inserts a parameterised number of wait states, and returns read data and PREADY to the downsizer. This makes the 32→16 conversion path testable end-to-end with real storage.

## Interface
- `WAIT_CYCLES`, default 1: number of ACCESS cycles with PREADY low before completion (0–15).
- `DEPTH`, default 64: number of halfword locations, addresses 0x00…(2*DEPTH-2).
- `ID_VALUE`, default 16'hA5B1: read-only contents of the top location, address 2*DEPTH-2.
- `PCLK` input 1: sole clock; all logic updates on the rising edge.
- `PRESET` input 1: reset, synchronous and active-high.
- `PSEL` input 1: select, from downsizer PSELm.
- `PENABLE` input 1: access phase, from PENABLEm.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PADDR` input 8: byte address; bit 0 ignored, so the halfword index is PADDR[7:1].
- `PWDATA` input 16: write data.
- `PRDATA` output 16: read data, registered.
- `PREADY` output 1: transfer completion, registered.
- `PSLVERR` output 1: error response; present only with the macro (see Configuration).

## Operation
- FSM states:
  - IDLE: PSEL low.
  - SETUP: PSEL high and PENABLE low, sampled.
  - WAIT: access phase with PREADY low.
  - READY: access phase with PREADY high.
- Transitions:
  - IDLE→SETUP on PSEL&!PENABLE. On this edge, `cnt` is loaded with 0.
  - SETUP→READY if WAIT_CYCLES==0, else SETUP→WAIT.
  - WAIT: `cnt` increments each cycle; WAIT→READY when cnt+1==WAIT_CYCLES.
  - READY: completes on the edge where PSEL&PENABLE&PREADY. It then returns to IDLE, or to SETUP if PSEL stays high with PENABLE low (back-to-back).
- Write: the array entry at PADDR[7:1] is updated with PWDATA only on the completion edge.
  - Writes to the ID location are dropped.
  - Writes to unmapped addresses (index ≥ DEPTH) are dropped.
- Read: PRDATA is loaded on the edge that raises PREADY.
  - The value is the array entry, or ID_VALUE for the ID location, or 16'h0000 when unmapped.
  - PRDATA is 16'h0000 whenever PREADY is low or PWRITE is high.
- Address, direction and write data are captured at SETUP. Changes during WAIT/READY are ignored.
- Boundary cases:
  - PSEL deasserts in WAIT or READY: abort, go to IDLE, no array write, PREADY→0.
  - PENABLE high in IDLE (no setup phase): ignored, PREADY stays 0.
  - PRESET mid-transfer: the transfer is abandoned, and the FSM, PREADY, PRDATA and the array all clear on that edge.

## Timing
- Reset values:
  - PRDATA = 16'h0000.
  - PREADY = 0.
  - PSLVERR = 0.
  - All array entries = 16'h0000.
  - FSM = IDLE, `cnt` = 0.
- A transfer occupies 1 setup cycle plus WAIT_CYCLES+1 access cycles. PREADY is high for exactly one cycle per completed transfer.
- Write data is visible to a read whose setup follows the completion edge; there is no read-after-write hazard.
- Each 32-bit downsizer transaction maps to two back-to-back 16-bit transfers, at PADDR and PADDR+2.

## Configuration
- `APB16_REGBANK_PSLVERR_EN` defined:
  - The PSLVERR port exists and is registered.
  - It is asserted together with PREADY for: unmapped addresses, writes to the ID location, and (checked at SETUP) an odd PADDR[0].
  - A write that errors does not modify the array.
- Macro undefined:
  - No PSLVERR port.
  - These same accesses complete silently: reads return 0, writes are dropped.
  - An odd PADDR[0] is simply ignored.

## Structure
- Package `apb16_pkg` holds:
  - `ADDR_W`=8 and `DATA_W`=16.
  - The FSM state typedef `apb16_state_t` {IDLE, SETUP, WAIT, READY}.
  - Default ID constant `APB16_ID_DEFAULT`.
- Sub-module `apb16_wait_ctrl` contains the FSM and wait counter. It outputs PREADY, the commit strobe and the abort strobe.
- The top level holds the address decode, array and read mux.

## Test plan
- Reset: assert PRESET for 2 cycles → PRDATA=0, PREADY=0, and a read of 0x00 returns 16'h0000.
- Write 0x44=16'h5678, then 0x46=16'h1234, with WAIT_CYCLES=1 → each transfer has PREADY low for 1 access cycle then high for 1. Reading back 0x44 and 0x46 returns 16'h5678 and 16'h1234.
- Repeat with WAIT_CYCLES=0 and 3 → PREADY rises in access cycle 1 and 4 respectively, and data is identical.
- Read ID location 0x7E → 16'hA5B1. Write 16'hFFFF to 0x7E, then read → still 16'hA5B1 (PSLVERR=1 on the write when enabled).
- Drop PSEL during WAIT of a write of 16'hBEEF to 0x10 → FSM returns to IDLE, and a read of 0x10 returns the prior value 16'h0000.
- Read 0x90 (unmapped) → PRDATA=16'h0000, PREADY completes, PSLVERR=1 if the macro is defined, else no port.

Source files
------------

// File: rtl/apb16_pkg.sv
// rtl/apb16_pkg.sv - shared widths, FSM state type and default ID for the 16-bit APB register bank
package apb16_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] APB16_ID_DEFAULT = 16'hA5B1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        READY = 2'd3
    } apb16_state_t;

endpackage

// File: rtl/apb16_wait_ctrl.sv
// rtl/apb16_wait_ctrl.sv - transfer FSM and wait-state counter; drives PREADY and setup/load/commit/abort strobes
module apb16_wait_ctrl
    import apb16_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready,
    output logic o_setup,
    output logic o_load,
    output logic o_commit,
    output logic o_abort
);

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    apb16_state_t r_state;
    apb16_state_t w_next;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;
    logic         r_pready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_pready <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_pready <= (w_next == READY);
        end
    end

    // The setup phase is resolved on the edge that samples it, so SETUP never
    // persists as a registered state; this keeps PREADY registered yet high in
    // access cycle WAIT_CYCLES+1.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        o_setup    = 1'b0;
        o_commit   = 1'b0;
        o_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    o_setup    = 1'b1;
                    w_cnt_next = 4'd0;
                    w_next     = (LP_WAIT == 4'd0) ? READY : WAIT;
                end
            end
            WAIT: begin
                if (!i_psel) begin
                    o_abort = 1'b1;
                    w_next  = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == LP_WAIT) begin
                        w_next = READY;
                    end
                end
            end
            READY: begin
                if (!i_psel) begin
                    o_abort = 1'b1;
                    w_next  = IDLE;
                end else if (i_penable) begin
                    o_commit = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_load   = (w_next == READY) && (r_state != READY);
    assign o_pready = r_pready;

endmodule

// File: rtl/apb16_regbank.sv
// rtl/apb16_regbank.sv - 16-bit APB completer with halfword array and wait states; APB16_REGBANK_PSLVERR_EN adds PSLVERR
module apb16_regbank
    import apb16_pkg::*;
#(
    parameter int                WAIT_CYCLES = 1,
    parameter int                DEPTH       = 64,
    parameter logic [DATA_W-1:0] ID_VALUE    = APB16_ID_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY
`ifdef APB16_REGBANK_PSLVERR_EN
    ,
    output logic              PSLVERR
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [7:0] LP_DEPTH  = 8'(DEPTH);
    localparam logic [6:0] LP_ID_IDX = 7'(DEPTH - 1);

    logic              w_setup;
    logic              w_load;
    logic              w_commit;
    logic              w_abort;

    logic [6:0]        r_idx;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_prdata;

    logic [6:0]        w_dec_idx;
    logic              w_dec_write;
    logic              w_mapped;
    logic              w_is_id;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd_value;

    apb16_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_psel    (PSEL),
        .i_penable (PENABLE),
        .o_pready  (PREADY),
        .o_setup   (w_setup),
        .o_load    (w_load),
        .o_commit  (w_commit),
        .o_abort   (w_abort)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_setup) begin
            r_idx   <= PADDR[ADDR_W-1:1];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
        end
    end

    // With zero wait states PRDATA loads on the setup edge itself, before the
    // captured copy exists, so decode looks through to the live bus then.
    assign w_dec_idx   = w_setup ? PADDR[ADDR_W-1:1] : r_idx;
    assign w_dec_write = w_setup ? PWRITE : r_write;
    assign w_mapped    = ({1'b0, w_dec_idx} < LP_DEPTH);
    assign w_is_id     = (w_dec_idx == LP_ID_IDX);

`ifdef APB16_REGBANK_PSLVERR_EN
    logic r_odd;
    logic w_dec_odd;
    logic r_pslverr;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_odd <= 1'b0;
        end else if (w_setup) begin
            r_odd <= PADDR[0];
        end
    end

    assign w_dec_odd = w_setup ? PADDR[0] : r_odd;
    assign w_wr_ok   = w_mapped && !w_is_id && !w_dec_odd;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_load && (!w_mapped || (w_dec_write && w_is_id) || w_dec_odd);
        end
    end

    assign PSLVERR = r_pslverr;

    always_comb begin
        w_rd_value = '0;
        if (w_mapped && !w_dec_odd) begin
            w_rd_value = w_is_id ? ID_VALUE : r_mem[w_dec_idx[IDX_W-1:0]];
        end
    end
`else
    assign w_wr_ok = w_mapped && !w_is_id;

    always_comb begin
        w_rd_value = '0;
        if (w_mapped) begin
            w_rd_value = w_is_id ? ID_VALUE : r_mem[w_dec_idx[IDX_W-1:0]];
        end
    end
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && r_write && w_wr_ok && !w_abort) begin
            r_mem[w_dec_idx[IDX_W-1:0]] <= r_wdata;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_prdata <= '0;
        end else begin
            r_prdata <= (w_load && !w_dec_write) ? w_rd_value : '0;
        end
    end

    assign PRDATA = r_prdata;

endmodule

// File: tb/tb_apb16_regbank.sv
// tb/tb_apb16_regbank.sv - scoreboard bench over three bank instances with 0, 1 and 3 wait states
module tb_apb16_regbank;

    logic        clk = 1'b0;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata [3];
    logic [2:0]  pready;
`ifdef APB16_REGBANK_PSLVERR_EN
    logic [2:0]  pslverr;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;
    int          wc [3]   = '{0, 1, 3};
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    apb16_regbank #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0])
`ifdef APB16_REGBANK_PSLVERR_EN
        , .PSLVERR(pslverr[0])
`endif
    );

    apb16_regbank #(.WAIT_CYCLES(1)) u_w1 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1])
`ifdef APB16_REGBANK_PSLVERR_EN
        , .PSLVERR(pslverr[1])
`endif
    );

    apb16_regbank #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2])
`ifdef APB16_REGBANK_PSLVERR_EN
        , .PSLVERR(pslverr[2])
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        psel    = 3'b000;
        penable = 1'b0;
        step();
    endtask

    // Leaves PSEL/PENABLE high after the completion edge so a following call is back-to-back.
    task automatic xfer(input int k, input logic wr, input logic [7:0] addr, input logic [15:0] wd);
        logic        done;
        logic [15:0] exp;
        done    = 1'b0;
        psel    = 3'b000;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        step();
        penable = 1'b1;
        for (int n = 1; n <= 40 && !done; n++) begin
            if (pready[k]) begin
                n_checks++;
                if (n != wc[k] + 1)
                    $display("FAIL latency inst%0d addr=%h: PREADY in access cycle %0d, required %0d", k, addr, n, wc[k] + 1);
                if (n != wc[k] + 1) n_fails++;
                if (!wr) begin
                    exp = exp_q.pop_front();
                    n_checks++;
                    if (prdata[k] !== exp) begin
                        $display("FAIL read_data inst%0d addr=%h: got %h, required %h", k, addr, prdata[k], exp);
                        n_fails++;
                    end
                end else begin
                    n_checks++;
                    if (prdata[k] !== 16'h0000) begin
                        $display("FAIL write_prdata inst%0d addr=%h: got %h, required 0000", k, addr, prdata[k]);
                        n_fails++;
                    end
                end
                done = 1'b1;
            end else begin
                n_checks++;
                if (prdata[k] !== 16'h0000) begin
                    $display("FAIL prdata_while_wait inst%0d addr=%h: got %h, required 0000", k, addr, prdata[k]);
                    n_fails++;
                end
            end
            step();
        end
        if (!done) begin
            $display("FAIL timeout inst%0d addr=%h: no PREADY within 40 cycles", k, addr);
            n_fails++;
            exp_q.delete();
        end else begin
            n_checks++;
            if (pready[k] !== 1'b0) begin
                $display("FAIL pready_one_cycle inst%0d addr=%h: got %b, required 0", k, addr, pready[k]);
                n_fails++;
            end
        end
    endtask

    task automatic do_read(input int k, input logic [7:0] addr, input logic [15:0] exp);
        exp_q.push_back(exp);
        xfer(k, 1'b0, addr, 16'h0000);
    endtask

    task automatic test_reset();
        preset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 16'h0000;
        step();
        step();
        preset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (prdata[k] !== 16'h0000 || pready[k] !== 1'b0) begin
                $display("FAIL reset_outputs inst%0d: PRDATA=%h PREADY=%b, required 0000 0", k, prdata[k], pready[k]);
                n_fails++;
            end
        end
        do_read(1, 8'h00, 16'h0000);
        bus_idle();
    endtask

    task automatic test_write_read(input int k);
        xfer(k, 1'b1, 8'h44, 16'h5678);
        xfer(k, 1'b1, 8'h46, 16'h1234);
        bus_idle();
        do_read(k, 8'h44, 16'h5678);
        do_read(k, 8'h46, 16'h1234);
        bus_idle();
    endtask

    task automatic test_id();
        do_read(1, 8'h7E, 16'hA5B1);
        bus_idle();
        xfer(1, 1'b1, 8'h7E, 16'hFFFF);
        bus_idle();
        do_read(1, 8'h7E, 16'hA5B1);
        bus_idle();
    endtask

    task automatic test_unmapped();
        do_read(1, 8'h90, 16'h0000);
        bus_idle();
        xfer(1, 1'b1, 8'h82, 16'h1111);
        bus_idle();
        do_read(1, 8'h02, 16'h0000);
        do_read(1, 8'h82, 16'h0000);
        bus_idle();
    endtask

    task automatic test_abort();
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 16'hBEEF;
        step();
        penable = 1'b1;
        step();
        psel    = 3'b000;
        penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (pready[2] !== 1'b0) begin
                $display("FAIL abort_pready cycle %0d: got %b, required 0", i, pready[2]);
                n_fails++;
            end
        end
        do_read(2, 8'h10, 16'h0000);
        bus_idle();
    endtask

    task automatic test_penable_idle();
        psel    = 3'b000;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (pready[1] !== 1'b0) begin
                $display("FAIL penable_in_idle cycle %0d: got %b, required 0", i, pready[1]);
                n_fails++;
            end
        end
        penable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        xfer(1, 1'b1, 8'h20, 16'hCAFE);
        bus_idle();
        do_read(1, 8'h20, 16'hCAFE);
        bus_idle();
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h22;
        pwdata  = 16'h7777;
        step();
        penable = 1'b1;
        preset  = 1'b1;
        step();
        preset  = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        n_checks++;
        if (pready[1] !== 1'b0 || prdata[1] !== 16'h0000) begin
            $display("FAIL reset_mid_outputs: PREADY=%b PRDATA=%h, required 0 0000", pready[1], prdata[1]);
            n_fails++;
        end
        step();
        do_read(1, 8'h20, 16'h0000);
        do_read(1, 8'h44, 16'h0000);
        do_read(1, 8'h22, 16'h0000);
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_write_read(0);
        test_write_read(1);
        test_write_read(2);
        test_id();
        test_unmapped();
        test_abort();
        test_penable_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
